// File: rtl/step_timing_conditioner.sv
// step_timing_conditioner: enforces driver-IC step/dir timing, buffers requests, blocks at limits, tracks position
module step_timing_conditioner #(
    parameter int DIR_SETUP_CYC = 10,
    parameter int PULSE_CYC     = 125,
    parameter int LOW_CYC       = 125,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               step_in,
    input  logic               dir_in,
    input  logic               limit_fwd,
    input  logic               limit_rev,
    input  logic               pos_clear,
    output logic               step_out,
    output logic               dir_out,
    output logic               busy,
    output logic signed [31:0] position,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        block_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
    state_t state, state_n;
    logic [15:0] timer, timer_n;
    logic step_n, dir_n, pop, blk, pos_upd;
    logic step_in_q, req, full, empty, push, hd;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [FIFO_DEPTH-1:0] mem;
    assign req   = enable & step_in & ~step_in_q;
    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign push  = req & (~full | pop);
    assign hd    = mem[rd_ptr];
    assign busy  = state != IDLE || !empty;
    // next-state: dir changes only from IDLE, so LOW phase doubles as dir hold
    always_comb begin
        state_n = state;
        timer_n = timer;
        step_n  = step_out;
        dir_n   = dir_out;
        pop     = 1'b0;
        blk     = 1'b0;
        pos_upd = 1'b0;
        case (state)
            IDLE: if (enable && !empty) begin
                if ((hd && limit_fwd) || (!hd && limit_rev)) begin
                    pop = 1'b1;
                    blk = 1'b1;
                end else if (hd != dir_out) begin
                    dir_n   = hd;
                    timer_n = 16'(DIR_SETUP_CYC - 1);
                    state_n = SETUP;
                end else begin
                    pop     = 1'b1;
                    step_n  = 1'b1;
                    timer_n = 16'(PULSE_CYC - 1);
                    state_n = HIGH;
                end
            end
            SETUP: if (!enable) state_n = IDLE;
                else if (timer == '0) begin
                    pop     = 1'b1;
                    step_n  = 1'b1;
                    timer_n = 16'(PULSE_CYC - 1);
                    state_n = HIGH;
                end else timer_n = timer - 16'd1;
            HIGH: if (timer == '0) begin
                    step_n  = 1'b0;
                    pos_upd = 1'b1;
                    timer_n = 16'(LOW_CYC - 1);
                    state_n = LOW;
                end else timer_n = timer - 16'd1;
            LOW: if (timer == '0) state_n = IDLE;
                else timer_n = timer - 16'd1;
            default: state_n = IDLE;
        endcase
    end
    // FIFO storage needs no reset; occupancy tracks validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dir_in;
    end
    // state, FIFO pointers, counters and position
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            step_out  <= 1'b0;
            dir_out   <= 1'b0;
            step_in_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            position  <= '0;
            drop_cnt  <= '0;
            block_cnt <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            step_out  <= step_n;
            dir_out   <= dir_n;
            step_in_q <= step_in;
            if (!enable) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (req && full && !pop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (blk && block_cnt != 16'hFFFF) block_cnt <= block_cnt + 16'd1;
            if (pos_clear) position <= '0;
            else if (pos_upd) position <= position + (dir_out ? 32'sd1 : -32'sd1);
        end
    end
endmodule
